// File: rtl/blink_pkg.sv
// Shared definitions for the blink generator and its start controller.
package blink_pkg;

  typedef enum logic {IDLE, RUN} start_state_t;

  // Smallest r such that 2**r >= n; 0 for n <= 1.
  function automatic int unsigned CeilLog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Number of clock cycles in period_ms milliseconds at base_clk Hz.
  function automatic int unsigned CountValue(input int unsigned base_clk,
                                             input int unsigned period_ms);
    return base_clk / 1000 * period_ms;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-time debouncer and one-cycle press pulse for an
// active-low push-button.
module button_debouncer
  import blink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned NBITS_DEBOUNCE = CeilLog2(DEBOUNCE_COUNT) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pressPulse
);

  localparam logic [NBITS_DEBOUNCE-1:0] LastCount = NBITS_DEBOUNCE'(DEBOUNCE_COUNT - 1);

  logic                      sync1;
  logic                      btn_s;
  logic                      level;
  logic                      level_prev;
  logic [NBITS_DEBOUNCE-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      btn_s      <= 1'b1;
      level      <= 1'b1;
      level_prev <= 1'b1;
      cnt        <= '0;
      pressPulse <= 1'b0;
    end else begin
      sync1      <= button_n;
      btn_s      <= sync1;
      level_prev <= level;
      // Only a 1 -> 0 transition of the debounced level is a press.
      pressPulse <= level_prev & ~level;
      if (btn_s != level) begin
        if (cnt == LastCount) begin
          level <= btn_s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/blink_start_ctrl.sv
// Toggles the blink generator's start on each debounced button press.
// Define BLINK_AUTO_STOP_EN to stop automatically after BLINK_LIMIT freqIn edges.
module blink_start_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned BASE_CLK       = 50000000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned DEBOUNCE_COUNT = CountValue(BASE_CLK, DEBOUNCE_MS),
  parameter int unsigned NBITS_DEBOUNCE = CeilLog2(DEBOUNCE_COUNT) + 1,
  parameter int unsigned BLINK_LIMIT    = 10,
  parameter int unsigned NBITS_BLINK    = CeilLog2(BLINK_LIMIT) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   button_n,
  input  logic                   freqIn,
  output logic                   start,
  output logic                   pressPulse,
  output logic [NBITS_BLINK-1:0] blinkCount
);

  start_state_t state;

  button_debouncer #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
    .NBITS_DEBOUNCE(NBITS_DEBOUNCE)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .button_n  (button_n),
    .pressPulse(pressPulse)
  );

`ifdef BLINK_AUTO_STOP_EN
  localparam bit AutoStop = (BLINK_LIMIT != 0);
  localparam logic [NBITS_BLINK-1:0] LastBlink =
      AutoStop ? NBITS_BLINK'(BLINK_LIMIT - 1) : '0;

  logic                   freqIn_d;
  logic                   freqIn_rise;
  logic [NBITS_BLINK-1:0] blink_cnt;

  assign freqIn_rise = freqIn & ~freqIn_d;
  assign blinkCount  = blink_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start     <= 1'b0;
      blink_cnt <= '0;
      freqIn_d  <= 1'b0;
    end else begin
      freqIn_d <= freqIn;
      unique case (state)
        IDLE: begin
          if (pressPulse) begin
            state     <= RUN;
            start     <= 1'b1;
            blink_cnt <= '0;
          end
        end
        RUN: begin
          // A press takes priority over a coincident edge, which is then not counted.
          if (pressPulse) begin
            state <= IDLE;
            start <= 1'b0;
          end else if (freqIn_rise) begin
            if (AutoStop && (blink_cnt == LastBlink)) begin
              state <= IDLE;
              start <= 1'b0;
            end
            if (blink_cnt != '1) blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end
`else
  localparam int unsigned unused_limit = BLINK_LIMIT;

  logic unused_freq;
  assign unused_freq = freqIn;
  assign blinkCount  = '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      start <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pressPulse) begin
            state <= RUN;
            start <= 1'b1;
          end
        end
        RUN: begin
          if (pressPulse) begin
            state <= IDLE;
            start <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_blink_start_ctrl.sv
// Directed, scoreboarded bench for blink_start_ctrl with DEBOUNCE_COUNT=4, BLINK_LIMIT=3.
module tb_blink_start_ctrl;

`ifdef BLINK_AUTO_STOP_EN
  localparam bit AutoStop = 1'b1;
`else
  localparam bit AutoStop = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       button_n = 1'b1;
  logic       freqIn   = 1'b0;
  logic       start;
  logic       pressPulse;
  logic [2:0] blinkCount;

  typedef struct {
    string      tag;
    logic       st;
    logic       pp;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  blink_start_ctrl #(
    .BASE_CLK   (1000),
    .DEBOUNCE_MS(4),
    .BLINK_LIMIT(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button_n  (button_n),
    .freqIn    (freqIn),
    .start     (start),
    .pressPulse(pressPulse),
    .blinkCount(blinkCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge,
  // then compare them against the DUT just after that edge.
  task automatic step(input string tag, input logic b, input logic f,
                      input logic st, input logic pp, input logic [2:0] cnt);
    exp_t e;
    button_n = b;
    freqIn   = f;
    e.tag = tag;
    e.st  = st;
    e.pp  = pp;
    e.cnt = AutoStop ? cnt : 3'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".start"}, {7'd0, start}, {7'd0, e.st});
    check({e.tag, ".pulse"}, {7'd0, pressPulse}, {7'd0, e.pp});
    check({e.tag, ".count"}, {5'd0, blinkCount}, {5'd0, e.cnt});
  endtask

  initial begin
    #2;
    check("reset.start", {7'd0, start}, 8'd0);
    check("reset.pulse", {7'd0, pressPulse}, 8'd0);
    check("reset.count", {5'd0, blinkCount}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Released button: nothing happens.
    for (int i = 0; i < 20; i++) step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Three-cycle glitch falls one cycle short of the debounce time.
    for (int i = 0; i < 3; i++) step("glitch_lo", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) step("glitch_hi", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Held press: pulse after edge 7, start after edge 8.
    for (int k = 1; k <= 8; k++) step("press1", 1'b0, 1'b0, k == 8, k == 7, 3'd0);

    // Release while counting three edges; the third stops the run.
    step("blink1",  1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    step("blink1h", 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    step("blink2",  1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    step("blink2h", 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    step("blink3",  1'b1, 1'b1, !AutoStop, 1'b0, 3'd3);
    step("blink3h", 1'b1, 1'b0, !AutoStop, 1'b0, 3'd3);
    step("frozen",  1'b1, 1'b1, !AutoStop, 1'b0, 3'd3);
    step("frozenh", 1'b1, 1'b0, !AutoStop, 1'b0, 3'd3);

    reset = 1'b0;
    #1;
    check("rst2.start", {7'd0, start}, 8'd0);
    check("rst2.count", {5'd0, blinkCount}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // New run, two edges, then a press coinciding with a third edge.
    for (int k = 1; k <= 8; k++) step("press2", 1'b0, 1'b0, k == 8, k == 7, 3'd0);
    step("pre1",  1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    step("pre1h", 1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    step("pre2",  1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    for (int i = 0; i < 5; i++) step("pre2h", 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    for (int k = 1; k <= 8; k++) step("collide", 1'b0, k == 8, k < 8, k == 7, 3'd2);
    step("idle_lo", 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    step("idle_rise", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

    // Start another run, then reset it mid-run with the button still held.
    for (int i = 0; i < 8; i++) step("release", 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    for (int k = 1; k <= 8; k++) step("press3", 1'b0, 1'b0, k == 8, k == 7, k == 8 ? 3'd0 : 3'd2);
    step("run3", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    reset = 1'b0;
    #1;
    check("midrst.start", {7'd0, start}, 8'd0);
    check("midrst.pulse", {7'd0, pressPulse}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) step("press4", 1'b0, 1'b0, k == 8, k == 7, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_start_ctrl.md
# blink_start_ctrl

Front-end controller that drives the `start` input of the blink generator from a raw push-button. It synchronizes and debounces the active-low button and emits a one-cycle press pulse. Each debounced press toggles `start`. Optionally, it stops the generator automatically after a programmed number of blinks by counting rising edges on the generator's `freqOut`, which feeds back into `freqIn`.

## Interface
- `BASE_CLK`, default 50000000: input clock frequency in Hz.
- `DEBOUNCE_MS`, default 10: required stable time in ms.
- `DEBOUNCE_COUNT`, default `BASE_CLK/1000*DEBOUNCE_MS`: stable-cycle count; must be ≥ 1.
- `NBITS_DEBOUNCE`, default `CeilLog2(DEBOUNCE_COUNT)+1`: debounce counter width.
- `BLINK_LIMIT`, default 10: rising edges of `freqIn` before auto-stop; 0 means unlimited.
- `NBITS_BLINK`, default `CeilLog2(BLINK_LIMIT)+1`: blink counter width.
- `clk`, in, 1: single clock. All logic runs on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `button_n`, in, 1: raw push-button, active low, asynchronous to `clk`.
- `freqIn`, in, 1: generator `freqOut`, synchronous to `clk`.
- `start`, out, 1: enable to the blink generator. Registered.
- `pressPulse`, out, 1: one-cycle pulse per debounced press. Registered.
- `blinkCount`, out, `NBITS_BLINK`: rising edges counted in the current run.

## Operation
- Reset values: `start`=0, `pressPulse`=0, `blinkCount`=0, both synchronizer flops=1, debounced level=1 (released), debounce counter=0, FSM=IDLE, `freqIn` delay flop=0.
- Synchronizer: two flops on `button_n`, producing `btn_s`.
- Debounce: the counter increments each cycle in which `btn_s` differs from the debounced level.
  - The counter clears on any cycle where they are equal.
  - When the counter equals `DEBOUNCE_COUNT-1` and `btn_s` still differs, the debounced level takes `btn_s` on the next edge and the counter clears.
  - The counter never wraps.
- Press detect: `pressPulse` is asserted for exactly one cycle, the cycle after the debounced level falls from 1 to 0. Release produces no pulse.
- Edge detect: `freqIn_rise = freqIn & ~freqIn_d`.
- FSM states:
  - IDLE: `start`=0.
  - RUN: `start`=1.
- Transitions:
  - IDLE → RUN on `pressPulse`. `blinkCount` clears on the same edge.
  - RUN → IDLE on `pressPulse` (manual stop).
  - RUN → IDLE on auto-stop: `freqIn_rise` while `blinkCount == BLINK_LIMIT-1` and `BLINK_LIMIT != 0`.
- Counting: in RUN, each `freqIn_rise` increments `blinkCount`. The count is frozen in IDLE and holds its final value until the next run starts.
- Simultaneous `pressPulse` and `freqIn_rise` in RUN: the press wins. The FSM goes to IDLE and `blinkCount` does not increment.
- With `BLINK_LIMIT=0`, `blinkCount` saturates at all-ones instead of wrapping.
- Asserting `reset` mid-run forces all reset values immediately. `start` drops asynchronously.

## Timing
- `button_n` falls and then stays low: `btn_s` follows 2 edges later.
- The debounced level falls `DEBOUNCE_COUNT` edges after `btn_s` changes.
- `pressPulse` is high on the following cycle.
- `start` rises on the edge after `pressPulse`.
- Total latency from a stable press to `start`=1 is `DEBOUNCE_COUNT+4` cycles.
- Auto-stop: `start` falls on the edge that samples the final `freqIn_rise`. `blinkCount` reads `BLINK_LIMIT` in the same cycle.
- Glitches shorter than `DEBOUNCE_COUNT` cycles on `btn_s` produce no change and no pulse.

## Configuration
- `BLINK_AUTO_STOP_EN` defined:
  - The auto-stop transition and the `blinkCount` logic are present, as described above.
- `BLINK_AUTO_STOP_EN` not defined:
  - Only button toggling controls `start`.
  - `blinkCount` is tied to 0.
  - `freqIn` is ignored, and its edge-detect flop is not instantiated.
  - `BLINK_LIMIT` has no effect.

## Structure
- Package `blink_pkg` contains:
  - The `CeilLog2` and `CountValue` functions shared with the blink generator.
  - `typedef enum logic {IDLE, RUN} start_state_t`.
- Sub-module `button_debouncer` contains the synchronizer, the debounce counter and the press pulse. It has ports `clk`, `reset`, `button_n`, `pressPulse` and parameter `DEBOUNCE_COUNT`.
- The top level holds the FSM, the `freqIn` edge detector and the blink counter.

## Test plan
All scenarios use `BASE_CLK=1000`, `DEBOUNCE_MS=4` (so `DEBOUNCE_COUNT=4`), `BLINK_LIMIT=3`, and `BLINK_AUTO_STOP_EN` defined.
- Reset, then hold `button_n`=1 for 20 cycles → `start`=0, `pressPulse`=0, `blinkCount`=0 throughout.
- `button_n` low for 3 cycles, then high → no `pressPulse`, and `start` stays 0.
- `button_n` held low from cycle 0 → `pressPulse` high only in cycle 7, and `start`=1 from cycle 8.
- In RUN, drive 3 `freqIn` rising edges → `blinkCount` counts 1, 2, 3, and `start` falls on the edge sampling the third rise.
- In RUN with `blinkCount`=2, a `pressPulse` coincides with a `freqIn` rise → `start`=0 and `blinkCount` stays 2.
- Assert `reset` while `start`=1 → `start` drops to 0 immediately, and the next press requires the full debounce latency again.
